// File: rtl/aer_spike_frame_tx.sv
// aer_spike_frame_tx: streams packed T x WIDTH spike frames from a byte buffer as
// 4-phase AER events, one per set pixel, plus an end-of-timestep marker per timestep.
module aer_spike_frame_tx #(
    parameter int          T           = 8,
    parameter int          WIDTH       = 784,
    parameter int          ADDR_W      = 20,
    parameter logic [11:0] MARKER_ADDR = 12'h4FF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [ADDR_W-1:0] SAMPLE_BASE,
    output logic              BUSY,
    output logic              DONE,
    output logic [15:0]       EVT_CNT,
    output logic              MEM_REN,
    output logic [ADDR_W-1:0] MEM_RADDR,
    input  logic [7:0]        MEM_RDATA,
    output logic [11:0]       AERIN_ADDR,
    output logic              AERIN_REQ,
    input  logic              AERIN_ACK
);
    localparam int             NB     = WIDTH / 8;
    localparam int             TW     = (T > 1) ? $clog2(T) : 1;
    localparam logic [6:0]     LAST_B = 7'(NB - 1);
    localparam logic [TW-1:0]  LAST_T = TW'(T - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_SCAN, S_SETUP, S_REQ_HI, S_REQ_LO
    } state_t;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [6:0]        r_bidx;
    logic [TW-1:0]     r_t;
    logic [7:0]        r_work;
    logic [11:0]       r_aer;
    logic              r_marker;
    logic              r_done;
    logic [15:0]       r_cnt;
    logic [2:0]        w_b;
    logic              w_start;

    assign BUSY       = (r_state != S_IDLE) || r_done;
    assign DONE       = r_done;
    assign EVT_CNT    = r_cnt;
    assign MEM_REN    = (r_state == S_FETCH);
    assign MEM_RADDR  = r_addr;
    assign AERIN_ADDR = r_aer;
    assign AERIN_REQ  = (r_state == S_REQ_HI);
    assign w_start    = START && !BUSY;

    // Highest set bit of the work register is the lowest remaining pixel (MSB-first).
    always_comb begin
        w_b = '0;
        for (int i = 0; i < 8; i++)
            if (r_work[i]) w_b = 3'(i);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = w_start ? S_FETCH : S_IDLE;
            S_FETCH:  w_next = S_LOAD;
            S_LOAD:   w_next = S_SCAN;
            S_SCAN:   w_next = (r_work != 8'd0 || r_bidx == LAST_B) ? S_SETUP : S_FETCH;
            S_SETUP:  w_next = AERIN_ACK ? S_SETUP : S_REQ_HI;
            S_REQ_HI: w_next = AERIN_ACK ? S_REQ_LO : S_REQ_HI;
            S_REQ_LO: w_next = AERIN_ACK ? S_REQ_LO :
                               !r_marker ? S_SCAN :
                               (r_t == LAST_T) ? S_IDLE : S_FETCH;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_addr   <= '0;
            r_bidx   <= '0;
            r_t      <= '0;
            r_work   <= '0;
            r_aer    <= '0;
            r_marker <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (w_start) begin
                    r_addr <= SAMPLE_BASE;
                    r_bidx <= '0;
                    r_t    <= '0;
                    r_cnt  <= '0;
                end
                S_LOAD: r_work <= MEM_RDATA;
                S_SCAN: if (r_work != 8'd0) begin
                    r_aer    <= {2'b00, r_bidx, ~w_b};
                    r_work   <= r_work & ~(8'd1 << w_b);
                    r_marker <= 1'b0;
                end else if (r_bidx == LAST_B) begin
                    r_aer    <= MARKER_ADDR;
                    r_marker <= 1'b1;
                end else begin
                    r_bidx <= r_bidx + 7'd1;
                    r_addr <= r_addr + 1'b1;
                end
                S_REQ_LO: if (!AERIN_ACK) begin
                    if (!r_marker)
                        r_cnt <= (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
                    else if (r_t == LAST_T)
                        r_done <= 1'b1;
                    else begin
                        r_t    <= r_t + 1'b1;
                        r_bidx <= '0;
                        r_addr <= r_addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aer_spike_frame_tx.sv
// tb_aer_spike_frame_tx: directed and random samples checked against a frame-level
// event model, with a memory model and a delayed 4-phase ACK responder.
module tb_aer_spike_frame_tx;
    localparam int NBYTES = 784;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [19:0] SAMPLE_BASE = '0;
    logic        BUSY, DONE, MEM_REN, AERIN_REQ;
    logic [15:0] EVT_CNT;
    logic [19:0] MEM_RADDR;
    logic [7:0]  MEM_RDATA = '0;
    logic [11:0] AERIN_ADDR;
    logic        AERIN_ACK = 1'b0;

    aer_spike_frame_tx dut (
        .CLK(CLK), .RST(RST), .START(START), .SAMPLE_BASE(SAMPLE_BASE),
        .BUSY(BUSY), .DONE(DONE), .EVT_CNT(EVT_CNT),
        .MEM_REN(MEM_REN), .MEM_RADDR(MEM_RADDR), .MEM_RDATA(MEM_RDATA),
        .AERIN_ADDR(AERIN_ADDR), .AERIN_REQ(AERIN_REQ), .AERIN_ACK(AERIN_ACK)
    );

    initial forever #5 CLK = ~CLK;

    int          checks = 0;
    int          errs = 0;
    logic [7:0]  mem [0:NBYTES-1];
    logic [19:0] cur_base = '0;
    logic [19:0] off;
    logic [11:0] exp_q[$];
    logic [11:0] obs_q[$];
    int          exp_evt;
    int          ren_cnt = 0;
    int          done_cnt = 0;
    int          ack_dly = 0;
    int          ack_wait = 0;
    int          req_len = 0;
    bit          long_chk = 0;
    logic        prev_req = 1'b0;
    logic [11:0] held = '0;

    // Monitor, memory model and ACK responder share one negedge process to keep ordering fixed.
    always @(negedge CLK) begin
        if (MEM_REN) begin
            checks++;
            assert (MEM_RADDR === cur_base + 20'(ren_cnt)) else begin
                errs++;
                $error("FAIL ren_addr obs=%h exp=%h", MEM_RADDR, cur_base + 20'(ren_cnt));
            end
            off = MEM_RADDR - cur_base;
            MEM_RDATA = (off < 20'(NBYTES)) ? mem[off] : 8'h00;
            ren_cnt++;
        end
        if (DONE) done_cnt++;
        if (AERIN_REQ && !prev_req) begin
            checks++;
            assert (AERIN_ACK === 1'b0) else begin
                errs++;
                $error("FAIL req_while_ack obs=%b exp=0", AERIN_ACK);
            end
            obs_q.push_back(AERIN_ADDR);
            held = AERIN_ADDR;
            req_len = 0;
        end
        if (AERIN_REQ || AERIN_ACK) begin
            checks++;
            assert (AERIN_ADDR === held) else begin
                errs++;
                $error("FAIL addr_stable obs=%h exp=%h", AERIN_ADDR, held);
            end
        end
        if (AERIN_REQ) req_len++;
        if (!AERIN_REQ && prev_req && long_chk) begin
            checks++;
            assert (req_len >= 100) else begin
                errs++;
                $error("FAIL req_hold obs=%0d exp=>=100", req_len);
            end
        end
        prev_req = AERIN_REQ;
        if (AERIN_REQ != AERIN_ACK) begin
            if (ack_wait >= ack_dly) begin
                AERIN_ACK = AERIN_REQ;
                ack_wait = 0;
            end else ack_wait++;
        end else ack_wait = 0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Reference: walk pixels of each timestep in order, then emit the marker.
    task automatic build_exp();
        exp_q = {};
        exp_evt = 0;
        for (int t = 0; t < 8; t++) begin
            for (int p = 0; p < 784; p++) begin
                int f = t * 784 + p;
                if (mem[f / 8][7 - (f % 8)]) begin
                    exp_q.push_back(12'(p));
                    exp_evt++;
                end
            end
            exp_q.push_back(12'h4FF);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < NBYTES; i++) mem[i] = 8'h00;
    endtask

    task automatic rand_mem();
        for (int i = 0; i < NBYTES; i++)
            mem[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
    endtask

    task automatic prep(input logic [19:0] base, input int dly);
        cur_base = base;
        ack_dly = dly;
        build_exp();
        obs_q = {};
        ren_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic pulse_start(input logic [19:0] base);
        @(negedge CLK);
        SAMPLE_BASE = base;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic run(input string tag, input logic [19:0] base, input int dly, input bit spurious);
        int cyc;
        int bad;
        prep(base, dly);
        pulse_start(base);
        if (spurious) begin
            repeat (12) @(negedge CLK);
            SAMPLE_BASE = base + 20'd16;
            START = 1'b1;
            @(negedge CLK);
            START = 1'b0;
            SAMPLE_BASE = base;
        end
        cyc = 0;
        while (done_cnt == 0 && cyc < 20000) begin
            @(negedge CLK);
            cyc++;
        end
        repeat (2) @(negedge CLK);
        check($sformatf("%s_done", tag), done_cnt, 1);
        check($sformatf("%s_nevents", tag), obs_q.size(), exp_q.size());
        bad = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (bad < 0 && (i >= obs_q.size() || obs_q[i] !== exp_q[i])) bad = i;
        check($sformatf("%s_first_bad_event", tag), bad, -1);
        check($sformatf("%s_evt_cnt", tag), EVT_CNT, exp_evt);
        check($sformatf("%s_ren_cnt", tag), ren_cnt, NBYTES);
        check($sformatf("%s_busy_after", tag), BUSY, 0);
    endtask

    initial begin
        int cyc;
        logic [19:0] base;
        clear_mem();
        repeat (3) @(negedge CLK);
        check("rst_req", AERIN_REQ, 0);
        check("rst_addr", AERIN_ADDR, 0);
        check("rst_ren", MEM_REN, 0);
        check("rst_raddr", MEM_RADDR, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_evt", EVT_CNT, 0);
        RST = 1'b0;

        @(negedge CLK);
        RST = 1'b1;
        START = 1'b1;
        SAMPLE_BASE = 20'h12345;
        @(negedge CLK);
        RST = 1'b0;
        START = 1'b0;
        @(negedge CLK);
        check("start_with_rst_busy", BUSY, 0);
        check("start_with_rst_ren", MEM_REN, 0);

        run("all_zero", 20'h00100, 0, 0);
        check("all_zero_first", obs_q.size() > 0 ? 32'(obs_q[0]) : 32'hDEAD, 12'h4FF);

        clear_mem();
        mem[0] = 8'h80;
        run("byte0_80", 20'h0ABC0, 0, 0);
        check("byte0_first", obs_q.size() > 0 ? 32'(obs_q[0]) : 32'hDEAD, 12'h000);

        clear_mem();
        mem[783] = 8'h01;
        run("byte783_01", 20'hFF000, 0, 0);
        check("byte783_last_pix", obs_q.size() >= 2 ? 32'(obs_q[obs_q.size()-2]) : 32'hDEAD, 12'h30F);

        clear_mem();
        mem[98] = 8'hFF;
        run("byte98_ff", 20'h00007, 0, 0);
        check("byte98_evt2", obs_q.size() >= 3 ? 32'(obs_q[2]) : 32'hDEAD, 12'h001);

        for (int r = 0; r < 3; r++) begin
            rand_mem();
            run($sformatf("rand%0d", r), 20'($urandom_range(0, 20'hFF000)), r, r == 1);
        end

        clear_mem();
        for (int k = 0; k < 3; k++) mem[$urandom_range(0, NBYTES - 1)] = 8'($urandom_range(1, 255));
        long_chk = 1;
        run("slow_ack", 20'h40000, 100, 0);
        long_chk = 0;

        rand_mem();
        mem[0] = 8'hE0;
        base = 20'h0F0F0;
        prep(base, 5);
        pulse_start(base);
        cyc = 0;
        while (!(obs_q.size() >= 3 && AERIN_REQ) && cyc < 2000) begin
            @(posedge CLK);
            #1;
            cyc++;
        end
        check("mid_req_high", AERIN_REQ, 1);
        check("mid_evt_before", EVT_CNT, 2);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check("mid_rst_req", AERIN_REQ, 0);
        check("mid_rst_busy", BUSY, 0);
        check("mid_rst_evt", EVT_CNT, 0);
        check("mid_rst_addr", AERIN_ADDR, 0);
        check("mid_rst_raddr", MEM_RADDR, 0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (5) @(negedge CLK);
        check("mid_rst_no_done", done_cnt, 0);
        run("replay", base, 0, 0);
        check("replay_first", obs_q.size() > 0 ? 32'(obs_q[0]) : 32'hDEAD, 12'h000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end
endmodule

// File: doc/aer_spike_frame_tx.md
# aer_spike_frame_tx

Hardware AER event source for the FF-STDP core. It reads one sample of packed binary spike frames from a byte-wide sample buffer: T timesteps × 784 pixels, MSB-first. It emits one 4-phase AER event per set pixel on the core's AERIN port, followed by an end-of-timestep marker after each timestep. It sits directly upstream of `Top_test` and replaces the behavioural spike player in on-chip training/inference runs.

## Interface

Parameters:
- `T`, 8: timesteps per sample.
- `WIDTH`, 784: pixels per timestep. Must be a multiple of 8 and ≤ 1023.
- `ADDR_W`, 20: sample-buffer byte address width.
- `MARKER_ADDR`, 12'h4FF: AER address of the end-of-timestep marker (bit10 = 1, low 10 bits = 0x0FF).

Ports:
- `CLK` in 1: single clock.
- `RST` in 1: synchronous, active-high reset.
- `START` in 1: one-cycle pulse that begins a sample. Ignored while `BUSY`.
- `SAMPLE_BASE` in ADDR_W: byte address of the sample's first byte. Latched on an accepted `START`.
- `BUSY` out 1: high from the cycle after an accepted `START` through the `DONE` cycle.
- `DONE` out 1: one-cycle pulse after the final marker's handshake completes.
- `EVT_CNT` out 16: number of pixel events sent in the current or last sample. Markers are excluded.
- `MEM_REN` out 1: sample-buffer read enable.
- `MEM_RADDR` out ADDR_W: sample-buffer read address.
- `MEM_RDATA` in 8: read data, valid exactly one cycle after `MEM_REN`.
- `AERIN_ADDR` out 12: event address. Pixel events use {2'b00, pix[9:0]}.
- `AERIN_REQ` out 1: 4-phase request.
- `AERIN_ACK` in 1: 4-phase acknowledge. Same clock domain; sampled directly with no synchronizer.

## Operation

- Memory layout: the flat bit index is f = t·WIDTH + pix. It maps to byte `SAMPLE_BASE + f/8`, bit `7 − f%8`. One timestep is WIDTH/8 bytes (98 bytes); one sample is T·WIDTH/8 bytes (784 bytes).
- State machine: IDLE → FETCH → LOAD → SCAN → SETUP → REQ_HI → REQ_LO → SCAN …
  - FETCH: assert `MEM_REN` for one cycle at the current byte address.
  - LOAD: register `MEM_RDATA` into an 8-bit work register.
  - SCAN: a priority encoder selects the highest remaining set bit b. It drives `AERIN_ADDR` = byte_in_step·8 + (7 − b), clears bit b, and goes to SETUP.
    - If the work register is zero and the timestep has bytes left: advance the byte address and go to FETCH.
    - If the timestep's last byte is exhausted: drive `AERIN_ADDR` = `MARKER_ADDR` and go to SETUP with a marker flag set.
  - SETUP: one cycle with `AERIN_ADDR` stable and `AERIN_REQ` low. Exit only when `AERIN_ACK` = 0.
  - REQ_HI: hold `AERIN_REQ` = 1 until `AERIN_ACK` = 1.
  - REQ_LO: hold `AERIN_REQ` = 0 until `AERIN_ACK` = 0.
    - Pixel event: increment `EVT_CNT`, return to SCAN.
    - Marker, t < T−1: increment t, advance the byte address, go to FETCH.
    - Marker, t = T−1: pulse `DONE`, go to IDLE.
- Events within a timestep go out in ascending pixel order. A zero byte costs 3 cycles (FETCH, LOAD, SCAN). Exactly T markers are sent per sample, even if all bits are zero.
- `EVT_CNT` clears on an accepted `START` and saturates at 16'hFFFF.
- `AERIN_ADDR` changes only in SCAN, never while `AERIN_REQ` = 1 or while `AERIN_ACK` = 1.

## Timing

- Reset values: `AERIN_REQ` = 0, `AERIN_ADDR` = 0, `MEM_REN` = 0, `MEM_RADDR` = 0, `BUSY` = 0, `DONE` = 0, `EVT_CNT` = 0. State = IDLE.
- `START` is sampled at edge k:
  - `MEM_REN` is high in cycle k+1 with `MEM_RADDR` = `SAMPLE_BASE`.
  - Data is registered at edge k+2 (LOAD).
  - SCAN is at k+3, and `AERIN_ADDR` is valid after edge k+3.
  - With `AERIN_ACK` low, `AERIN_REQ` rises after edge k+4.
- `AERIN_REQ` falls the cycle after `AERIN_ACK` = 1 is sampled.
- The next event's earliest `AERIN_REQ` rise is 3 cycles after `AERIN_ACK` = 0 is sampled: SCAN, then SETUP, then REQ rises.
- `RST` mid-sample: at the next edge, all outputs return to reset values, including `AERIN_REQ` = 0 mid-handshake. No `DONE` pulse. Re-`START` replays the sample from byte 0.
- `START` coincident with `RST`: `RST` wins.
- `START` while `BUSY`: ignored, with no effect on `SAMPLE_BASE`.
- `DONE` and a new `START` in the same cycle: that `START` is ignored. Accept `START` from the following cycle.

## Test plan

- All-zero sample, instant ACK → exactly 8 events, all `AERIN_ADDR` = 0x4FF; 784 `MEM_REN` pulses at BASE…BASE+783; one `DONE`; `EVT_CNT` = 0.
- Byte 0 = 0x80, rest zero → first event 0x000, then 8 markers; `EVT_CNT` = 1.
- Byte 783 = 0x01 → last pixel event 0x30F (pixel 783, t = 7) immediately before the final 0x4FF marker.
- Byte 98 = 0xFF → after the first marker, events 0x000…0x007 in ascending order, then the t = 1 marker; `EVT_CNT` = 8.
- ACK responder with 100-cycle delay on both edges → `AERIN_REQ` held high ≥ 100 cycles; `AERIN_ADDR` unchanged across every handshake; no new REQ while ACK is high.
- `RST` asserted while `AERIN_REQ` = 1 at the third event → `AERIN_REQ` = 0, `BUSY` = 0 next cycle, no `DONE`. A new `START` replays from pixel event 1, and `EVT_CNT` restarts from 0.
